meas_counter_arbiter: RTL
=========================

Name: meas_counter_arbiter

Overview:
- Owns one 32-bit cycle counter and shares it between NREQ measurement requesters using round-robin arbitration.
- A granted requester holds the counter until it pulses stop or a timeout limit is reached.
- The block then reports the elapsed cycle count, the requester ID and a timeout flag.
- Sits between the bootloader/test sequencers and the timing-measurement datapath.

Parameters:
- NREQ, 4, number of requesters (2..8); IDW = clog2(NREQ), derived.
- TIMEOUT, 32'hFFFF_FFFF, count value at which a run is force-terminated (must be >= 1).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request, level; sampled only in IDLE.
- stop  in  NREQ  per-requester stop, 1-cycle pulse; only the owner's bit is honoured.
- grant  out  NREQ  one-hot ownership, registered.
- busy  out  1  high in RUN and DONE.
- result  out  32  measured cycle count, held until the next result.
- result_id  out  IDW  index of the requester that owned the result.
- result_valid  out  1  1-cycle pulse in DONE.
- timeout  out  1  qualifies result; held with result.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, count=0, grant=0, busy=0, result=0, result_id=0, result_valid=0, timeout=0, rr_ptr=NREQ-1. Effective immediately, including mid-RUN; an interrupted run produces no result.
- Reset release: logic leaves reset on the first clk edge with rst=1.
- States are IDLE, RUN and DONE. The counter is internal; only result is visible.
- IDLE:
  - If req != 0, select the first set bit searching from index (rr_ptr+1) mod NREQ upward, wrapping.
  - Next edge: state=RUN, grant=onehot(sel), rr_ptr=sel, count=0, busy=1.
  - If req == 0, stay in IDLE with grant=0.
- RUN: grant is held and count increments by 1 every cycle.
  - Stop: if stop[owner]=1 on an edge, result<=count, timeout<=0, result_id<=owner, state<=DONE. A stop in the first RUN cycle gives result=0.
  - Timeout: if stop[owner]=0 and count==TIMEOUT-1, result<=TIMEOUT, timeout<=1, result_id<=owner, state<=DONE.
  - Priority: stop wins over timeout on the same edge.
  - stop bits of non-owners are ignored in every state. The owner's req level is don't-care during RUN; dropping it does not abort.
  - count never wraps, because the run ends at TIMEOUT.
- DONE: lasts exactly one cycle, with grant=0, result_valid=1 and busy=1. Next edge goes to IDLE.
- Back-to-back runs: arbitration resumes in IDLE, so there is at least 1 IDLE cycle between runs. The minimum period per run is 3 cycles (IDLE, RUN, DONE).
- Fairness: with all req bits held high, grants rotate 0,1,2,...,NREQ-1,0. No requester waits more than NREQ-1 other runs.
- Output holding: result, result_id and timeout only change on the transition from RUN to DONE, and otherwise hold their values.
- Invariant: grant is one-hot or zero at every cycle; never two bits set.

Test Plan:
- Reset, then req=4'b0001, stop[0] pulsed on the 10th RUN cycle (count=9) → grant=0001 for 10 cycles, result=9, result_id=0, timeout=0, result_valid high for exactly one cycle.
- req=4'b1111 held, each owner stops after 2 RUN cycles → grant sequence 0001, 0010, 0100, 1000, 0001, each result=1, result_id=0,1,2,3,0.
- TIMEOUT=16, owner never stops → run ends after 16 RUN cycles, result=16, timeout=1. Then a normal run with stop clears timeout to 0.
- During a run owned by 1, pulse stop[0] and stop[2] and drop req[1] → run continues; stop[1] at count=5 gives result=5, result_id=1.
- Assert rst=0 mid-RUN at count=7 → grant, busy and result_valid drop to 0 asynchronously. After release, with req=0010, a new run starts with count=0 and result_id=1.
- stop[owner] in the first RUN cycle, and separately TIMEOUT=16 with stop arriving on the timeout edge (count=15) → result=0 with timeout=0; and result=15 with timeout=0 (stop wins).

Source files
------------

// File: rtl/meas_counter_arbiter_if.sv
// Handshake bundle between measurement requesters and the shared
// cycle-counter arbiter.
interface meas_counter_arbiter_if #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] stop;
    logic [NREQ-1:0] grant;
    logic            busy;
    logic [31:0]     result;
    logic [IDW-1:0]  result_id;
    logic            result_valid;
    logic            timeout;

    modport master (
        output req, stop,
        input  grant, busy, result,
        input  result_id, result_valid, timeout
    );

    modport slave (
        input  req, stop,
        output grant, busy, result,
        output result_id, result_valid, timeout
    );
endinterface

// File: rtl/meas_counter_arbiter.sv
// Round-robin shared 32-bit cycle counter: one owner at a time measures
// elapsed cycles until it pulses stop or the run hits TIMEOUT.
module meas_counter_arbiter #(
    parameter  int          NREQ    = 4,
    parameter  logic [31:0] TIMEOUT = 32'hFFFF_FFFF,
    localparam int          IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    meas_counter_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [31:0]    LIM     = TIMEOUT - 32'd1;
    localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);

    state_t          r_state;
    logic [31:0]     r_count;
    logic [NREQ-1:0] r_grant;
    logic [IDW-1:0]  r_rr_ptr;
    logic [31:0]     r_result;
    logic [IDW-1:0]  r_result_id;
    logic            r_timeout;

    state_t          w_state_n;
    logic [31:0]     w_count_n;
    logic [NREQ-1:0] w_grant_n;
    logic [IDW-1:0]  w_rr_n;
    logic [31:0]     w_result_n;
    logic [IDW-1:0]  w_rid_n;
    logic            w_to_n;

    logic [IDW-1:0]  w_cand;
    logic [IDW-1:0]  w_sel;
    logic            w_found;
    logic            w_stop_own;

    // Search starts one past the last owner, so every requester
    // waits behind at most NREQ-1 other runs.
    always_comb begin
        w_cand  = '0;
        w_sel   = '0;
        w_found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = IDW'((int'(r_rr_ptr) + i) % NREQ);
            if (!w_found && bus.req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    // During RUN the pointer doubles as the owner index.
    assign w_stop_own = bus.stop[r_rr_ptr];

    always_comb begin
        w_state_n  = r_state;
        w_count_n  = r_count;
        w_grant_n  = r_grant;
        w_rr_n     = r_rr_ptr;
        w_result_n = r_result;
        w_rid_n    = r_result_id;
        w_to_n     = r_timeout;
        unique case (r_state)
            S_IDLE: begin
                w_grant_n = '0;
                if (w_found) begin
                    w_state_n = S_RUN;
                    w_grant_n = NREQ'(1) << w_sel;
                    w_rr_n    = w_sel;
                    w_count_n = '0;
                end
            end
            S_RUN: begin
                if (w_stop_own) begin
                    w_state_n  = S_DONE;
                    w_grant_n  = '0;
                    w_result_n = r_count;
                    w_rid_n    = r_rr_ptr;
                    w_to_n     = 1'b0;
                end else if (r_count == LIM) begin
                    w_state_n  = S_DONE;
                    w_grant_n  = '0;
                    w_result_n = TIMEOUT;
                    w_rid_n    = r_rr_ptr;
                    w_to_n     = 1'b1;
                end else begin
                    w_count_n = r_count + 32'd1;
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
                w_grant_n = '0;
            end
            default: begin
                w_state_n = S_IDLE;
                w_grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_grant     <= '0;
            r_rr_ptr    <= PTR_RST;
            r_result    <= '0;
            r_result_id <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_count     <= w_count_n;
            r_grant     <= w_grant_n;
            r_rr_ptr    <= w_rr_n;
            r_result    <= w_result_n;
            r_result_id <= w_rid_n;
            r_timeout   <= w_to_n;
        end
    end

    assign bus.grant        = r_grant;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.result       = r_result;
    assign bus.result_id    = r_result_id;
    assign bus.result_valid = (r_state == S_DONE);
    assign bus.timeout      = r_timeout;

endmodule
